// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the 16-point FFT operand reader.
package fft_pkg;
  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 4;
  localparam int LOG2N        = 4;
  localparam int N_POINTS     = 16;
  localparam int BF_PER_STAGE = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WB, DONE} state_t;
endpackage

// File: rtl/fft_bf_addr_gen.sv
// Radix-2 DIT butterfly address/twiddle generator: (stage, b) -> (a, bx, tw).
// Purely combinational. Sized for the 16-point transform (stage 0..3, b 0..7).
module fft_bf_addr_gen #(
  parameter int ADDR_W = fft_pkg::ADDR_W
) (
  input  logic [1:0]        stage,
  input  logic [2:0]        b,
  output logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] bx,
  output logic [2:0]        tw
);
  logic [ADDR_W-1:0] bb;
  logic [ADDR_W-1:0] half;
  logic [2:0]        mask;
  logic [2:0]        sh1;

  assign bb   = ADDR_W'(b);
  assign half = ADDR_W'(1) << stage;
  // Low 'stage' bits of b select the position inside a butterfly group.
  assign mask = ~(3'b111 << stage);
  assign sh1  = {1'b0, stage} + 3'd1;

  // Group base plus in-group offset; partner sits 'half' above.
  always_comb begin
    a  = ((bb >> stage) << sh1) + ADDR_W'(b & mask);
    bx = a + half;
    tw = (b & mask) << (2'd3 - stage);
  end
endmodule

// File: rtl/fft_operand_reader.sv
// Read-side sequencer for the 16-point FFT working memory.
// Walks 4 DIT stages x 8 butterflies, reads both operands, and hands each pair
// to the butterfly over valid/ready; a stage barrier waits for 8 write-back acks.
// Optional: define FFT_RD_STALL_CNT_EN to add the 16-bit stall_cnt output.
module fft_operand_reader #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int ADDR_W = fft_pkg::ADDR_W,
  parameter int LOG2N  = fft_pkg::LOG2N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr_1,
  output logic [ADDR_W-1:0] rd_addr_2,
  input  logic [DATA_W-1:0] rd_data_1,
  input  logic [DATA_W-1:0] rd_data_2,
  output logic              bf_valid,
  input  logic              bf_ready,
  output logic [DATA_W-1:0] bf_data_a,
  output logic [DATA_W-1:0] bf_data_b,
  output logic [ADDR_W-1:0] bf_addr_a,
  output logic [ADDR_W-1:0] bf_addr_b,
  output logic [2:0]        bf_tw_idx,
  output logic [1:0]        bf_stage,
  input  logic              wb_ack
`ifdef FFT_RD_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  import fft_pkg::*;

  localparam logic [1:0] LAST_STAGE = 2'(LOG2N - 1);
  localparam logic [2:0] LAST_BF    = 3'(BF_PER_STAGE - 1);
  localparam logic [3:0] WB_FULL    = 4'(BF_PER_STAGE);

  typedef struct packed {
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [2:0]        tw;
    logic [1:0]        stage;
  } bf_req_t;

  state_t            state_q, state_d;
  logic [1:0]        stage_q;
  logic [2:0]        b_q;
  logic [3:0]        wb_cnt_q, wb_cnt_nxt;
  logic              ack_cnt_en, load, bf_vld_q;
  logic [ADDR_W-1:0] gen_a, gen_bx;
  logic [2:0]        gen_tw;
  bf_req_t           bf_q;

  fft_bf_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .stage (stage_q),
    .b     (b_q),
    .a     (gen_a),
    .bx    (gen_bx),
    .tw    (gen_tw)
  );

  // Output slot is free when empty or being taken this cycle.
  assign load       = (state_q == ISSUE) && (!bf_vld_q || bf_ready);
  // Acks only count while a stage is live, and saturate at one full stage.
  assign ack_cnt_en = wb_ack && (state_q == ISSUE || state_q == WAIT_WB) && (wb_cnt_q != WB_FULL);
  assign wb_cnt_nxt = wb_cnt_q + {3'b000, ack_cnt_en};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and status/read-address outputs.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    rd_addr_1 = '0;
    rd_addr_2 = '0;
    unique case (state_q)
      IDLE: if (start) state_d = ISSUE;
      ISSUE: begin
        busy      = 1'b1;
        rd_addr_1 = gen_a;
        rd_addr_2 = gen_bx;
        if (load && b_q == LAST_BF) state_d = WAIT_WB;
      end
      WAIT_WB: begin
        busy = 1'b1;
        if (wb_cnt_nxt == WB_FULL) state_d = (stage_q == LAST_STAGE) ? DONE : ISSUE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage, butterfly and write-back ack counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q  <= '0;
      b_q      <= '0;
      wb_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          stage_q  <= '0;
          b_q      <= '0;
          wb_cnt_q <= '0;
        end
        ISSUE: begin
          if (load) b_q <= b_q + 3'd1;
          wb_cnt_q <= wb_cnt_nxt;
        end
        WAIT_WB: begin
          if (wb_cnt_nxt == WB_FULL && stage_q != LAST_STAGE) begin
            stage_q  <= stage_q + 2'd1;
            b_q      <= '0;
            wb_cnt_q <= '0;
          end else begin
            wb_cnt_q <= wb_cnt_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand pair register; drains on handshake in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_vld_q <= 1'b0;
      bf_q     <= '0;
    end else if (load) begin
      bf_vld_q <= 1'b1;
      bf_q     <= '{data_a: rd_data_1, data_b: rd_data_2, addr_a: gen_a,
                    addr_b: gen_bx, tw: gen_tw, stage: stage_q};
    end else if (bf_ready) begin
      bf_vld_q <= 1'b0;
    end
  end

  assign bf_valid  = bf_vld_q;
  assign bf_data_a = bf_q.data_a;
  assign bf_data_b = bf_q.data_b;
  assign bf_addr_a = bf_q.addr_a;
  assign bf_addr_b = bf_q.addr_b;
  assign bf_tw_idx = bf_q.tw;
  assign bf_stage  = bf_q.stage;

`ifdef FFT_RD_STALL_CNT_EN
  logic [15:0] stall_q;

  // Back-pressure cycle counter, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         stall_q <= '0;
    else if (state_q == IDLE && start)                  stall_q <= '0;
    else if (bf_vld_q && !bf_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_fft_operand_reader.sv
// Self-checking bench for fft_operand_reader: transaction scoreboard plus a
// stage-barrier model checked every cycle, and directed literal expectations.
module tb_fft_operand_reader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, bf_ready = 1'b0, wb_ack = 1'b0;
  logic        busy, done, bf_valid;
  logic [3:0]  rd_addr_1, rd_addr_2, bf_addr_a, bf_addr_b;
  logic [31:0] rd_data_1, rd_data_2, bf_data_a, bf_data_b;
  logic [2:0]  bf_tw_idx;
  logic [1:0]  bf_stage;
`ifdef FFT_RD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk = 0, n_fail = 0;
  // model / driver state
  int phase = 0, m_stage = 0, m_cnt = 0, acc = 0, m_stall = 0, done_seen = 0;
  int owed = 0, ack_no = 0, hold_idx = -1, hold_left = 0, extra = 0;
  logic        p_valid = 1'b0, p_ready = 1'b0;
  logic [45:0] p_fields = '0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [3:0] i);
    return {12'hA5C, i, 12'h000, i};
  endfunction

  assign rd_data_1 = mem_val(rd_addr_1);
  assign rd_data_2 = mem_val(rd_addr_2);

  fft_operand_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .bf_data_a(bf_data_a), .bf_data_b(bf_data_b),
    .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b), .bf_tw_idx(bf_tw_idx), .bf_stage(bf_stage),
    .wb_ack(wb_ack)
`ifdef FFT_RD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // k-th pair of a transform: stage k/8, butterfly k%8, from the DIT index rules.
  task automatic exp_pair(input int k, output logic [3:0] a, output logic [3:0] bx,
                          output logic [2:0] tw, output logic [1:0] s);
    int ss, b, half, ai;
    ss = k / 8; b = k % 8; half = 1 << ss;
    ai = (b / half) * 2 * half + b % half;
    a  = 4'(ai);
    bx = 4'(ai + half);
    tw = 3'((b % half) * (8 / half));
    s  = 2'(ss);
  endtask

  // Compare process: checks every cycle, then advances the model across the next edge.
  always @(negedge clk) begin
    logic [3:0] ea, eb;
    logic [2:0] et;
    logic [1:0] es;
    int issued, ins, n;
    if (!rst_n) begin
      phase = 0; m_stage = 0; m_cnt = 0; acc = 0; owed = 0; m_stall = 0; p_valid = 1'b0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_valid", 32'(bf_valid), 0);
      chk("rst_rdaddr", {24'h0, rd_addr_1, rd_addr_2}, 0);
      chk("rst_fields", {15'h0, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage}, 0);
      chk("rst_data", bf_data_a | bf_data_b, 0);
    end else begin
      issued = acc + int'(bf_valid);
      ins = issued - 8 * m_stage;
      if (ins < 0) ins = 0;
      chk("busy", 32'(busy), 32'(phase == 1));
      chk("done", 32'(done), 32'(phase == 2));
      if (phase == 1 && ins < 8) begin
        exp_pair(m_stage * 8 + ins, ea, eb, et, es);
        chk("rd_addr", {24'h0, rd_addr_1, rd_addr_2}, {24'h0, ea, eb});
      end else begin
        chk("rd_addr_idle", {24'h0, rd_addr_1, rd_addr_2}, 0);
      end
      if (p_valid && !p_ready) begin
        chk("hold_valid", 32'(bf_valid), 1);
        chk("hold_fields", 32'({bf_data_a[3:0], bf_data_b[3:0], bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage}),
            32'({p_fields[45:42], p_fields[41:38], p_fields[12:0]}));
      end
`ifdef FFT_RD_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
      if (done) done_seen++;
      if (bf_valid && bf_ready) begin
        exp_pair(acc, ea, eb, et, es);
        chk("pair_addr", {24'h0, bf_addr_a, bf_addr_b}, {24'h0, ea, eb});
        chk("pair_tw_stage", {27'h0, bf_tw_idx, bf_stage}, {27'h0, et, es});
        chk("pair_data_a", bf_data_a, mem_val(ea));
        chk("pair_data_b", bf_data_b, mem_val(eb));
        acc++;
        owed++;
      end
      if (phase == 0 && start) m_stall = 0;
      else if (bf_valid && !bf_ready && m_stall < 16'hFFFF) m_stall++;
      case (phase)
        0: if (start) begin phase = 1; m_stage = 0; m_cnt = 0; acc = 0; end
        1: begin
          n = m_cnt + ((wb_ack && m_cnt < 8) ? 1 : 0);
          if (ins == 8 && n == 8) begin
            if (m_stage == 3) phase = 2;
            else begin m_stage++; m_cnt = 0; end
          end else m_cnt = n;
        end
        default: phase = 0;
      endcase
      p_valid  = bf_valid;
      p_ready  = bf_ready;
      p_fields = {bf_data_a[3:0], bf_data_b[3:0], 25'h0, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage};
    end
  end

  // Write-back responder: one ack per accepted pair, a cycle later; optional hold and extras.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin wb_ack = 1'b0; owed = 0; end
      else if (owed > 0 && ack_no == hold_idx && hold_left > 0) begin hold_left--; wb_ack = 1'b0; end
      else if (owed > 0) begin wb_ack = 1'b1; owed--; ack_no++; end
      else if (extra > 0) begin wb_ack = 1'b1; extra--; end
      else wb_ack = 1'b0;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_addr(input logic [3:0] x, input logic [3:0] y, input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (rd_addr_1 == x && rd_addr_2 == y) return;
    end
    timeout(name);
  endtask

  task automatic wait_pair(input logic [1:0] s, input logic [3:0] x, input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (bf_valid && bf_stage == s && bf_addr_a == x) return;
    end
    timeout(name);
  endtask

  task automatic wait_done(input int d0, input string name);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (done) begin
        repeat (4) @(posedge clk);
        #2 chk(name, 32'(done_seen - d0), 1);
        return;
      end
    end
    timeout(name);
  endtask

  initial begin
    int d0;
    bf_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full transform: latency, first/last pairs, stage 2 b=5 literals.
    ack_no = 0; d0 = done_seen;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    #1 chk("lat_c1_busy", 32'(busy), 1);
    chk("lat_c1_valid", 32'(bf_valid), 0);
    @(posedge clk); #2;
    chk("lat_c2_valid", 32'(bf_valid), 1);
    chk("first_pair", {20'h0, bf_addr_a, bf_addr_b, bf_tw_idx, 1'b0}, {20'h0, 4'd0, 4'd1, 3'd0, 1'b0});
    chk("first_data", bf_data_b, 32'hA5C1_0001);
    wait_pair(2'd0, 4'd14, "wait_s0b7");
    chk("s0b7", {21'h0, bf_addr_b, bf_tw_idx}, {21'h0, 4'd15, 3'd0});
    wait_pair(2'd2, 4'd9, "wait_s2b5");
    chk("s2b5_addr_b", 32'(bf_addr_b), 13);
    chk("s2b5_tw", 32'(bf_tw_idx), 2);
    chk("s2b5_data", {bf_data_a[3:0], bf_data_b[3:0]}, 8'h9D);
    wait_pair(2'd3, 4'd7, "wait_s3b7");
    chk("s3b7", {21'h0, bf_addr_b, bf_tw_idx}, {21'h0, 4'd15, 3'd7});
    wait_done(d0, "done_once_t2");

    // Back-pressure on pair 4 of stage 1 for 3 cycles.
    d0 = done_seen;
    pulse_start();
    wait_addr(4'd8, 4'd10, "wait_s1b4");
    @(posedge clk); #1 bf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_pair", {24'h0, bf_addr_a, bf_addr_b}, {24'h0, 4'd8, 4'd10});
      @(posedge clk);
    end
    #1 bf_ready = 1'b1;
    wait_done(d0, "done_once_t4");
`ifdef FFT_RD_STALL_CNT_EN
    chk("stall_total", 32'(stall_cnt), 3);
`endif

    // Withhold the 8th ack of stage 0 for 10 cycles.
    repeat (4) @(posedge clk);
    d0 = done_seen; ack_no = 0; hold_idx = 7; hold_left = 10;
    pulse_start();
    for (int i = 0; i < 100 && ack_no < 7; i++) begin @(posedge clk); #2; end
    repeat (5) @(posedge clk);
    #2 chk("barrier_busy", 32'(busy), 1);
    chk("barrier_no_read", {24'h0, rd_addr_1, rd_addr_2}, 0);
    chk("barrier_valid", 32'(bf_valid), 0);
    for (int i = 0; i < 30 && ack_no < 8; i++) begin @(posedge clk); #2; end
    chk("hold_elapsed", 32'(hold_left), 0);
    chk("ack8_seen", 32'(ack_no), 8);
    @(posedge clk); #2;
    chk("resume_s1b0", {24'h0, rd_addr_1, rd_addr_2}, {24'h0, 4'd0, 4'd2});
    hold_idx = -1;
    wait_done(d0, "done_once_t5");

    // Start while busy and extra acks: ignored, sequence unchanged.
    repeat (4) @(posedge clk);
    d0 = done_seen; extra = 2;
    pulse_start();
    repeat (3) @(posedge clk);
    pulse_start();
    wait_done(d0, "done_once_t6");
    extra = 2;
    repeat (6) @(posedge clk);
    #2 chk("idle_after_extra", 32'(busy), 0);

    // Reset mid-ISSUE at stage 1 b=3, then a clean full transform.
    repeat (10) @(posedge clk);
    d0 = done_seen;
    pulse_start();
    wait_addr(4'd5, 4'd7, "wait_s1b3");
    rst_n = 1'b0;
    #1 chk("abort_outs", {22'h0, busy, done, bf_valid, rd_addr_1, rd_addr_2}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    pulse_start();
    wait_done(d0, "done_once_after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
